// File: rtl/nios2_debug_vjtag_host.sv
// ---------------------------------------------------------------------------
// nios2_debug_vjtag_host
//
// Drives the SLD-hub side of a Nios II debug slave's virtual-JTAG port, so
// that debug-slave scans can run without a hardware JTAG chain. Each accepted
// request runs one scan: UIR -> CDR -> SDR (DR_WIDTH periods) -> UDR ->
// RTI (RTI_HOLD periods). The scan result is then presented until the
// consumer takes it.
//
// Every vji_tck period is 2*TCK_DIV clk cycles: a low phase followed by a
// high phase. Strobes, TDI and IR change only when vji_tck falls, or on the
// accept edge while vji_tck is already low.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   scan request handshake (cmd_ready = idle)
//   cmd_ir, cmd_dr        IR value and DR value (shifted LSB first)
//   rsp_valid/rsp_ready   scan result handshake
//   rsp_dr                DR bits returned by the slave (bit k = k-th out)
//   rsp_ir_out            vji_ir_out sampled at the vji_tck rise in UIR
//   vji_tck, vji_tdi      generated test clock and serial data to the slave
//   vji_tdo               serial data from the slave
//   vji_ir_in, vji_ir_out IR to the slave / IR status from the slave
//   vji_uir/cdr/sdr/udr   one-hot virtual state strobes
//   vji_rti               run-test-idle indication (idle, RTI and response)
// ---------------------------------------------------------------------------
module nios2_debug_vjtag_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4,
    parameter int RTI_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int PH_W    = $clog2(2 * TCK_DIV);
    localparam int CNT_MAX = (DR_WIDTH > RTI_HOLD) ? DR_WIDTH : RTI_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PH_W-1:0]     r_ph;    // clk cycle within the current tck period
    logic [CNT_W-1:0]    r_per;   // tck period within the current state
    logic [DR_WIDTH-1:0] r_dr;    // remaining TDI bits, LSB goes out next
    logic [DR_WIDTH-1:0] r_cap;   // TDO bits, shifted in from the MSB side

    logic w_active;
    logic w_rise;
    logic w_fall;
    logic w_accept;

    assign cmd_ready = (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_active  = (r_state != S_IDLE) && (r_state != S_RESP);
    // w_rise: the edge that drives vji_tck high; w_fall: the edge that ends
    // the period, drives vji_tck low and moves the scan on.
    assign w_rise    = w_active && (r_ph == PH_W'(TCK_DIV - 1));
    assign w_fall    = w_active && (r_ph == PH_W'(2 * TCK_DIV - 1));

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (cmd_valid)                                    w_next = S_UIR;
            S_UIR:  if (w_fall)                                       w_next = S_CDR;
            S_CDR:  if (w_fall)                                       w_next = S_SDR;
            S_SDR:  if (w_fall && r_per == CNT_W'(DR_WIDTH - 1))      w_next = S_UDR;
            S_UDR:  if (w_fall)                                       w_next = S_RTI;
            S_RTI:  if (w_fall && r_per == CNT_W'(RTI_HOLD - 1))      w_next = S_RESP;
            S_RESP: if (rsp_ready)                                    w_next = S_IDLE;
            default:                                                  w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are decoded from the next state and registered, so the strobes
    // switch on the same edge as the state (the falling-tck edge or accept).
    // NOTE: the shift and capture registers are reset as well, so an aborted
    // scan leaves nothing behind that a later scan could expose.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ph       <= '0;
            r_per      <= '0;
            r_dr       <= '0;
            r_cap      <= '0;
            vji_tck    <= 1'b0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            vji_rti    <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_dr     <= '0;
            rsp_ir_out <= '0;
        end else begin
            r_ph <= (w_active && !w_fall) ? r_ph + 1'b1 : '0;

            if (w_next != r_state) begin
                r_per <= '0;
            end else if (w_fall) begin
                r_per <= r_per + 1'b1;
            end

            if (w_rise) begin
                vji_tck <= 1'b1;
            end else if (w_fall) begin
                vji_tck <= 1'b0;
            end

            vji_uir   <= (w_next == S_UIR);
            vji_cdr   <= (w_next == S_CDR);
            vji_sdr   <= (w_next == S_SDR);
            vji_udr   <= (w_next == S_UDR);
            vji_rti   <= (w_next == S_IDLE) || (w_next == S_RTI) || (w_next == S_RESP);
            rsp_valid <= (w_next == S_RESP);

            // TDI for the next period is presented as the current one ends;
            // it is parked low outside Shift-DR.
            if (w_accept) begin
                vji_ir_in <= cmd_ir;
                r_dr      <= cmd_dr;
            end else if (w_fall) begin
                if (w_next == S_SDR) begin
                    vji_tdi <= r_dr[0];
                    r_dr    <= r_dr >> 1;
                end else begin
                    vji_tdi <= 1'b0;
                end
            end

            // TDO is taken on the edge that raises vji_tck, before the slave
            // reacts to that rising edge.
            if (r_state == S_SDR && w_rise) begin
                r_cap <= {vji_tdo, r_cap[DR_WIDTH-1:1]};
            end

            if (r_state == S_UIR && w_rise) begin
                rsp_ir_out <= vji_ir_out;
            end

            if (r_state == S_UDR && w_fall) begin
                rsp_dr <= r_cap;
            end
        end
    end

endmodule
